// File: rtl/decoder_scan.sv
// decoder_scan: a registered N-to-2^N one-hot decoder with selectable output
// polarity, an active-low enable and an auto-scan mode.
//
// In direct mode the index i_w is decoded onto o_y with one cycle of latency.
// In scan mode a prescaler counts DIV clock cycles per step. At the end of
// each step the index advances by one, wrapping from 2^N-1 back to 0, so a
// single instance can drive multiplexed digit or row selects.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    asynchronous, active-high reset
//   i_w      [N-1:0]    index to decode in direct mode
//   i_s      output polarity: 1 = active-high one-hot, 0 = active-low one-cold
//   i_en_n   active-low enable: 0 = enabled, 1 = disabled
//   i_mode   0 = direct decode of i_w, 1 = auto-scan
//   o_y      [2^N-1:0]  registered decoded lines; bit i corresponds to index i
//   o_idx    [N-1:0]    registered index currently shown on o_y
//   o_tick   registered one-cycle pulse marking a scan advance
module decoder_scan #(
  parameter int N   = 2,
  parameter int DIV = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N-1:0]       i_w,
  input  logic               i_s,
  input  logic               i_en_n,
  input  logic               i_mode,
  output logic [(1<<N)-1:0]  o_y,
  output logic [N-1:0]       o_idx,
  output logic               o_tick
);

  localparam int W  = 1 << N;
  // The prescaler is always at least one bit wide, so DIV=1 still has a counter.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PC_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_pc;
  logic [PW-1:0]   w_pc_nxt;
  logic [N-1:0]    r_idx;
  logic [N-1:0]    w_idx_nxt;
  logic [W-1:0]    r_y;
  logic [W-1:0]    w_y_nxt;
  logic            r_tick;
  logic            w_tick_nxt;

  // Active pattern for index i: one-hot when s=1, one-cold when s=0.
  function automatic logic [W-1:0] pat(input logic [N-1:0] i, input logic s);
    logic [W-1:0] oh;
    oh    = {W{1'b0}};
    oh[i] = 1'b1;
    return s ? oh : ~oh;
  endfunction

  // Pattern with no line active: all zeros when s=1, all ones when s=0.
  function automatic logic [W-1:0] inactive(input logic s);
    return s ? {W{1'b0}} : {W{1'b1}};
  endfunction

  // Next-state and next-output logic. The action taken at an edge follows the
  // state being entered, so the enable and mode inputs override a due advance.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_idx_nxt   = r_idx;
    w_y_nxt     = r_y;
    w_tick_nxt  = 1'b0;

    if (i_en_n) begin
      w_state_nxt = ST_OFF;
    end else if (i_mode) begin
      w_state_nxt = ST_SCAN;
    end else begin
      w_state_nxt = ST_DIRECT;
    end

    case (w_state_nxt)
      ST_OFF: begin
        // The index and prescaler hold. Only the polarity of the blank pattern can change.
        w_y_nxt = inactive(i_s);
      end
      ST_DIRECT: begin
        w_idx_nxt = i_w;
        w_y_nxt   = pat(i_w, i_s);
        w_pc_nxt  = {PW{1'b0}};
      end
      ST_SCAN: begin
        if (r_state != ST_SCAN) begin
          // The entry edge restarts the step count. Any partial count is discarded and no advance occurs.
          w_pc_nxt = {PW{1'b0}};
        end else if (r_pc == PC_LAST) begin
          w_pc_nxt   = {PW{1'b0}};
          w_idx_nxt  = r_idx + N'(1);
          w_tick_nxt = 1'b1;
        end else begin
          w_pc_nxt = r_pc + PW'(1);
        end
        // Decode from the new index so that o_y and o_idx always agree.
        w_y_nxt = pat(w_idx_nxt, i_s);
      end
      default: begin
        w_y_nxt = inactive(i_s);
      end
    endcase
  end

  // State, prescaler and output registers. Reset clears all of them immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_OFF;
      r_pc    <= {PW{1'b0}};
      r_idx   <= {N{1'b0}};
      r_y     <= {W{1'b0}};
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_idx   <= w_idx_nxt;
      r_y     <= w_y_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign o_y    = r_y;
  assign o_idx  = r_idx;
  assign o_tick = r_tick;

endmodule
